// File: rtl/bridge_arb_pkg.sv
// bridge_arb_pkg: shared widths and arbiter state encoding.
// DRAIN is present only when BRIDGE_ARB_TIMEOUT_EN is defined.
package bridge_arb_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
`ifdef BRIDGE_ARB_TIMEOUT_EN
    , DRAIN
`endif
  } arb_state_e;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin pick of the first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win,
  output logic             any
);
  logic [IDX_W-1:0] j;
  always_comb begin
    win = '0;
    j = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = IDX_W'((int'(ptr) + k) % N_REQ);
      if (req_valid[j]) win = j;
    end
  end
  assign any = |req_valid;
endmodule

// File: rtl/bridge_arbiter.sv
// bridge_arbiter: round-robin sharing of the bridge C-side port, one transaction in flight.
// Define BRIDGE_ARB_TIMEOUT_EN to add the WAIT timeout abort and the DRAIN state.
module bridge_arbiter
  import bridge_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_r_wb,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data_w,
  output logic [N_REQ-1:0]        req_ack,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    C_in_valid,
  output logic [ADDR_W-1:0]       C_addr,
  output logic                    C_r_wb,
  output logic [DATA_W-1:0]       C_data_w,
  input  logic                    C_out_valid,
  input  logic [DATA_W-1:0]       C_data_r
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_cfg_check
    $error("bridge_arbiter: unsupported N_REQ or TIMEOUT");
  end

  arb_state_e state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, win_q, win_d, pick;
  logic any;
  logic r_wb_q, r_wb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_a [N_REQ];
  logic [DATA_W-1:0] wdata_a [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = req_data_w[g*DATA_W +: DATA_W];
  end

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_valid(req_valid),
    .ptr(ptr_q),
    .win(pick),
    .any(any)
  );

`ifdef BRIDGE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    r_wb_d = r_wb_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef BRIDGE_ARB_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: if (any) begin
        state_d = ISSUE;
        win_d = pick;
        r_wb_d = req_r_wb[pick];
        addr_d = addr_a[pick];
        wdata_d = wdata_a[pick];
      end
      ISSUE: begin
        state_d = WAIT;
        ptr_d = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
`ifdef BRIDGE_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      WAIT: if (C_out_valid) begin
        state_d = RESP;
        rdata_d = r_wb_q ? C_data_r : '0;
`ifdef BRIDGE_ARB_TIMEOUT_EN
        err_d = 1'b0;
`endif
      end
`ifdef BRIDGE_ARB_TIMEOUT_EN
      else if (cnt_q + 1'b1 == CNT_W'(TIMEOUT)) begin
        state_d = RESP;
        rdata_d = '0;
        err_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      RESP: state_d = err_q ? DRAIN : IDLE;
      // The aborted transaction's late completion must be swallowed before rearbitrating
      DRAIN: if (C_out_valid) state_d = IDLE;
`else
      RESP: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      win_q <= '0;
      r_wb_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      r_wb_q <= r_wb_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end

`ifdef BRIDGE_ARB_TIMEOUT_EN
  always_ff @(posedge clk)
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  assign rsp_err = (state_q == RESP) & err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign C_in_valid = state_q == ISSUE;
  assign req_ack = (state_q == ISSUE) ? ONE << win_q : '0;
  assign rsp_valid = (state_q == RESP) ? ONE << win_q : '0;
  assign rsp_data = rdata_q;
  assign C_addr = addr_q;
  assign C_r_wb = r_wb_q;
  assign C_data_w = wdata_q;

  // A requester must have dropped its request before its own response
  assert property (@(posedge clk) disable iff (rst) (state_q == RESP) |-> !req_valid[win_q]);
endmodule

// File: doc/bridge_arbiter.md
# bridge_arbiter

Round-robin arbiter that shares the single AXI bridge C-side command port among `N_REQ` requesters. It serialises requests, one outstanding bridge transaction at a time, and drives the bridge's C_in_valid/C_addr/C_r_wb/C_data_w. It captures C_out_valid/C_data_r and returns the result to the requester that issued the transaction. It sits between the datapath clients and the bridge.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 1023: WAIT cycles before abort. Used only with `BRIDGE_ARB_TIMEOUT_EN`.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in N_REQ: per-requester request, held until acked.
- `req_r_wb` in N_REQ: 1 = read, 0 = write.
- `req_addr` in N_REQ*8: packed 8-bit C_addr per requester.
- `req_data_w` in N_REQ*64: packed write data.
- `req_ack` out N_REQ: one-cycle grant/accept pulse.
- `rsp_valid` out N_REQ: one-cycle completion pulse.
- `rsp_data` out 64: read data, or 0 for writes; shared by all requesters.
- `rsp_err` out 1: timeout abort flag, qualified by rsp_valid.
- `C_in_valid` out 1: bridge command pulse.
- `C_addr` out 8, `C_r_wb` out 1, `C_data_w` out 64: bridge command fields.
- `C_out_valid` in 1, `C_data_r` in 64: bridge completion.

## Operation
- States: IDLE, ISSUE, WAIT, RESP, DRAIN (DRAIN exists only with the macro).
- IDLE, any `req_valid`: the picker chooses the first set bit at or after `ptr`, wrapping. Latch index, r_wb, addr and data. Go to ISSUE.
- ISSUE, one cycle: `C_in_valid`=1 and `req_ack[win]`=1. Set `ptr` to win+1 mod N_REQ. Go to WAIT.
- WAIT: on `C_out_valid`, latch `C_data_r` (force 0 for writes) and go to RESP.
- RESP, one cycle: `rsp_valid[win]`=1, `rsp_data` valid, `rsp_err`=0. Go to IDLE.
- `C_*` fields hold their latched values from ISSUE until the next ISSUE. `rsp_data` holds until the next RESP.
- Requester rules:
  - Keep `req_valid` and its fields stable until `req_ack`. Deassert on the cycle after `req_ack`.
  - Do not re-request before your own `rsp_valid`. Violations are assertion errors.
- `C_out_valid` outside WAIT or DRAIN is ignored.
- Reset values: state=IDLE, `ptr`=0. Every output is 0: `req_ack`, `rsp_valid`, `rsp_data`, `rsp_err`, `C_in_valid`, `C_addr`, `C_r_wb`, `C_data_w`.
- Reset mid-operation drops the transaction with no `rsp_valid`. `rst` must be applied together with the bridge reset.

## Timing
- Request seen in IDLE at cycle t: `C_in_valid` and `req_ack` at t+1.
- `C_out_valid` at cycle u: `rsp_valid` at u+1. IDLE at u+2. Earliest next `C_in_valid` at u+3.
- A requester newly raising `req_valid` during WAIT is considered at the next IDLE. There is no pre-grant.
- A requester that drops out is skipped. Fairness: any pending requester is served within N_REQ grants.

## Configuration
- `BRIDGE_ARB_TIMEOUT_EN` defined: a WAIT counter, width $clog2(TIMEOUT+1), clears on entering WAIT.
  - Counter reaches TIMEOUT without `C_out_valid`: go to RESP with `rsp_err`=1 and `rsp_data`=0. Then go to DRAIN, not IDLE.
  - DRAIN waits for the one late `C_out_valid`, discards it, then goes to IDLE.
  - `C_out_valid` on the same cycle the counter hits TIMEOUT: normal completion, no error.
- Not defined: no counter and no DRAIN state. WAIT waits indefinitely. `rsp_err` is tied 0.

## Structure
- Package `bridge_arb_pkg`: `ADDR_W`=8, `DATA_W`=64, and the state enum `arb_state_e`.
- Sub-module `rr_picker`: combinational, inputs `req_valid` and `ptr`, outputs winner index and `any`.

## Test plan
- Read: req0 read addr 8'h05 at t. Required: `C_in_valid`=1, `C_addr`=8'h05, `C_r_wb`=1 and `req_ack[0]` at t+1. Bridge returns 64'hDEAD_BEEF_0000_0001. Required: `rsp_valid[0]` with that data one cycle after `C_out_valid`.
- Write: req1 write addr 8'hFF, data 64'h0123_4567_89AB_CDEF. Required: `C_data_w` matches, `C_r_wb`=0, and `rsp_valid[1]` with `rsp_data`=0.
- Contention: all four requesters raise `req_valid` at once after reset. Required: grants in order 0,1,2,3, with `ptr` ending at 0.
- Fairness: req0 re-requests immediately after each response while req2 is pending. Required: grant order 0,2,0,2.
- Timeout (macro on, TIMEOUT=16), no `C_out_valid`. Required: `rsp_valid` with `rsp_err`=1 16 cycles after entering WAIT. A late `C_out_valid` is swallowed in DRAIN, and the next request completes normally.
- Reset: assert `rst` in WAIT. Required: all outputs 0 the next cycle, no `rsp_valid`, and a fresh request is granted to req0.
